// File: rtl/btb_predictor_pkg.sv
// Shared types and constants for the branch target buffer.
// The direction counter encoding is named so that the table and the
// training logic speak the same language: the MSB is the taken prediction.
package btb_predictor_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bpctr_t;

    localparam int    BTB_CTR_W = 2;
    localparam word_t PC_STEP   = 32'd4;

    // Sequential fall-through PC; the carry out of bit 31 is dropped on purpose.
    function automatic word_t next_seq_pc(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// Saturating up/down counter next-value logic.
// Pure combinational: the caller owns the storage and decides when to write.
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             inc,
    output logic [CTR_W-1:0] next_ctr
);

    // Step toward the requested direction, holding at all-ones or zero.
    always_comb begin
        next_ctr = ctr;
        if (inc) begin
            if (ctr != {CTR_W{1'b1}}) begin
                next_ctr = ctr + {{(CTR_W-1){1'b0}}, 1'b1};
            end else begin
                next_ctr = ctr;
            end
        end else begin
            if (ctr != {CTR_W{1'b0}}) begin
                next_ctr = ctr - {{(CTR_W-1){1'b0}}, 1'b1};
            end else begin
                next_ctr = ctr;
            end
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Fetch looks up curr_pc combinationally; EX trains the table one
// resolved branch per cycle; invalidate flushes every valid bit. The table is
// kept as separate field arrays so each field can be written independently.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int               ENTRIES   = 4,
    parameter int               CTR_W     = BTB_CTR_W,
    parameter logic [CTR_W-1:0] CTR_ALLOC = 2'b10,
    parameter logic [CTR_W-1:0] CTR_RESET = 2'b01
) (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t curr_pc,
    output word_t bp_pc,
    output logic  bp_hit,
    output logic  bp_taken,
    input  logic  update_en,
    input  word_t update_pc,
    input  word_t update_target,
    input  logic  update_taken,
    input  logic  invalidate
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Table storage
    logic             valid_r  [ENTRIES];
    logic [TAG_W-1:0] tag_r    [ENTRIES];
    word_t            target_r [ENTRIES];
    logic [CTR_W-1:0] ctr_r    [ENTRIES];

    // Lookup side
    logic [IDX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic             lk_hit_s;
    logic             lk_taken_s;

    // Update side
    logic [IDX_W-1:0] up_idx_s;
    logic [TAG_W-1:0] up_tag_s;
    logic             up_hit_s;
    logic [CTR_W-1:0] up_ctr_s;
    logic [CTR_W-1:0] up_ctr_next_s;
    logic             do_train_s;
    logic             do_alloc_s;

    // The byte offset of a PC never selects anything; fold it away explicitly.
    logic             unused_pc_bits_s;
    assign unused_pc_bits_s = ^{curr_pc[1:0], update_pc[1:0]};

    // Split both PCs into table index and tag.
    always_comb begin
        lk_idx_s = curr_pc[IDX_W+1:2];
        lk_tag_s = curr_pc[31:IDX_W+2];
        up_idx_s = update_pc[IDX_W+1:2];
        up_tag_s = update_pc[31:IDX_W+2];
    end

    // Zero-latency prediction from the current (pre-update) table contents.
    always_comb begin
        lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        lk_taken_s = lk_hit_s && ctr_r[lk_idx_s][CTR_W-1];
        bp_hit     = lk_hit_s;
        bp_taken   = lk_taken_s;
        if (lk_taken_s) begin
            bp_pc = target_r[lk_idx_s];
        end else begin
            bp_pc = next_seq_pc(curr_pc);
        end
    end

    // Classify the resolved branch: train an existing entry or allocate a new one.
    // A flush in the same cycle suppresses both, so the flush always wins.
    always_comb begin
        up_hit_s   = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
        up_ctr_s   = ctr_r[up_idx_s];
        do_train_s = 1'b0;
        do_alloc_s = 1'b0;
        if (update_en && !invalidate) begin
            do_train_s = up_hit_s;
            do_alloc_s = !up_hit_s && update_taken;
        end else begin
            do_train_s = 1'b0;
            do_alloc_s = 1'b0;
        end
    end

    // Single shared counter stepper for the training path.
    sat_counter #(
        .CTR_W (CTR_W)
    ) u_sat_counter (
        .ctr      (up_ctr_s),
        .inc      (update_taken),
        .next_ctr (up_ctr_next_s)
    );

    // Table write port: reset, flush, train or allocate.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= 32'h0000_0000;
                ctr_r[i]    <= CTR_RESET;
            end
        end else if (invalidate) begin
            // Tags and targets are left alone; with valid cleared they are dead.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                ctr_r[i]   <= CTR_RESET;
            end
        end else begin
            if (do_train_s) begin
                ctr_r[up_idx_s] <= up_ctr_next_s;
                // A not-taken outcome says nothing about where the branch goes.
                if (update_taken) begin
                    target_r[up_idx_s] <= update_target;
                end
            end
            if (do_alloc_s) begin
                valid_r[up_idx_s]  <= 1'b1;
                tag_r[up_idx_s]    <= up_tag_s;
                target_r[up_idx_s] <= update_target;
                ctr_r[up_idx_s]    <= CTR_ALLOC;
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor. Two instances (4 and 16 entries) see the
// same stimulus; expected {hit, taken, next_pc} values are written per depth.
module tb_btb_predictor;
    import btb_predictor_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    word_t curr_pc;
    word_t update_pc;
    word_t update_target;
    logic  update_en;
    logic  update_taken;
    logic  invalidate;

    word_t bp_pc_w    [2];
    logic  bp_hit_w   [2];
    logic  bp_taken_w [2];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    btb_predictor #(.ENTRIES(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .curr_pc(curr_pc),
        .bp_pc(bp_pc_w[0]), .bp_hit(bp_hit_w[0]), .bp_taken(bp_taken_w[0]),
        .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken), .invalidate(invalidate)
    );

    btb_predictor #(.ENTRIES(16)) dut16 (
        .CLK(CLK), .nRST(nRST), .curr_pc(curr_pc),
        .bp_pc(bp_pc_w[1]), .bp_hit(bp_hit_w[1]), .bp_taken(bp_taken_w[1]),
        .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken), .invalidate(invalidate)
    );

    // Pack an expected {hit, taken, bp_pc} triple.
    function automatic logic [33:0] pk(input logic h, input logic t, input word_t pc);
        return {h, t, pc};
    endfunction

    task automatic next_cycle;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Present one resolved branch for exactly one rising edge.
    task automatic drive_update(input word_t pc, input word_t tgt, input logic tk);
        update_en     = 1'b1;
        update_pc     = pc;
        update_target = tgt;
        update_taken  = tk;
        next_cycle();
        update_en     = 1'b0;
    endtask

    task automatic test_reset;
        logic [33:0] e;
        nRST = 1'b0;
        curr_pc = 32'h0000_0040;
        @(negedge CLK);
        #1;
        e = pk(1'b0, 1'b0, 32'h0000_0044);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== e) begin
                errors++;
                $display("FAIL reset_lookup dut%0d: got hit=%0b taken=%0b pc=%h, want hit=%0b taken=%0b pc=%h",
                         d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d], e[33], e[32], e[31:0]);
            end
        end
        nRST = 1'b1;
        next_cycle();
    endtask

    task automatic test_allocate;
        logic [33:0] e [3];
        word_t pcs [3];
        string nm [3];
        pcs[0] = 32'h0000_0040; e[0] = pk(1'b1, 1'b1, 32'h0000_0100); nm[0] = "alloc_hit";
        pcs[1] = 32'h0000_0042; e[1] = pk(1'b1, 1'b1, 32'h0000_0100); nm[1] = "low_bits_ignored";
        pcs[2] = 32'hFFFF_FFFC; e[2] = pk(1'b0, 1'b0, 32'h0000_0000); nm[2] = "wrap_miss";
        drive_update(32'h0000_0040, 32'h0000_0100, 1'b1);
        for (int k = 0; k < 3; k++) begin
            curr_pc = pcs[k];
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== e[k]) begin
                    errors++;
                    $display("FAIL %s dut%0d: got hit=%0b taken=%0b pc=%h, want hit=%0b taken=%0b pc=%h",
                             nm[k], d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d], e[k][33], e[k][32], e[k][31:0]);
                end
            end
        end
    endtask

    // Each step: one update, then a lookup of pc_chk compared to the expected triple.
    task automatic test_train;
        word_t       u_pc  [10];
        word_t       u_tgt [10];
        logic        u_tk  [10];
        word_t       c_pc  [10];
        logic [33:0] e     [10];
        string       nm    [10];
        int          n;
        n = 0;
        // WEAK_T -> WEAK_NT
        u_pc[n] = 32'h40; u_tgt[n] = 32'h100; u_tk[n] = 1'b0; c_pc[n] = 32'h40; e[n] = pk(1'b1, 1'b0, 32'h44);  nm[n] = "train_nt"; n++;
        // WEAK_NT -> WEAK_T -> STRONG_T -> STRONG_T
        for (int r = 0; r < 3; r++) begin
            u_pc[n] = 32'h40; u_tgt[n] = 32'h100; u_tk[n] = 1'b1; c_pc[n] = 32'h40; e[n] = pk(1'b1, 1'b1, 32'h100); nm[n] = "train_t"; n++;
        end
        // STRONG_T -> WEAK_T; target must not follow a not-taken update
        u_pc[n] = 32'h40; u_tgt[n] = 32'h999; u_tk[n] = 1'b0; c_pc[n] = 32'h40; e[n] = pk(1'b1, 1'b1, 32'h100); nm[n] = "sat_hi_held"; n++;
        // WEAK_T -> WEAK_NT -> STRONG_NT -> STRONG_NT
        for (int r = 0; r < 3; r++) begin
            u_pc[n] = 32'h40; u_tgt[n] = 32'h100; u_tk[n] = 1'b0; c_pc[n] = 32'h40; e[n] = pk(1'b1, 1'b0, 32'h44); nm[n] = "sat_lo"; n++;
        end
        // STRONG_NT -> WEAK_NT -> WEAK_T with a new target
        u_pc[n] = 32'h40; u_tgt[n] = 32'h180; u_tk[n] = 1'b1; c_pc[n] = 32'h40; e[n] = pk(1'b1, 1'b0, 32'h44);  nm[n] = "sat_lo_held"; n++;
        u_pc[n] = 32'h40; u_tgt[n] = 32'h180; u_tk[n] = 1'b1; c_pc[n] = 32'h40; e[n] = pk(1'b1, 1'b1, 32'h180); nm[n] = "retrain_target"; n++;
        for (int k = 0; k < n; k++) begin
            drive_update(u_pc[k], u_tgt[k], u_tk[k]);
            curr_pc = c_pc[k];
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== e[k]) begin
                    errors++;
                    $display("FAIL %s step%0d dut%0d: got hit=%0b taken=%0b pc=%h, want hit=%0b taken=%0b pc=%h",
                             nm[k], k, d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d], e[k][33], e[k][32], e[k][31:0]);
                end
            end
        end
    endtask

    task automatic test_no_alloc_not_taken;
        logic [33:0] e [2];
        word_t pcs [2];
        string nm [2];
        // 0xC0 shares index 0 with 0x40 at both depths
        pcs[0] = 32'h0000_00C0; e[0] = pk(1'b0, 1'b0, 32'h0000_00C4); nm[0] = "nt_no_alloc";
        pcs[1] = 32'h0000_0040; e[1] = pk(1'b1, 1'b1, 32'h0000_0180); nm[1] = "nt_miss_no_evict";
        drive_update(32'h0000_00C0, 32'h0000_0700, 1'b0);
        for (int k = 0; k < 2; k++) begin
            curr_pc = pcs[k];
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== e[k]) begin
                    errors++;
                    $display("FAIL %s dut%0d: got hit=%0b taken=%0b pc=%h, want hit=%0b taken=%0b pc=%h",
                             nm[k], d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d], e[k][33], e[k][32], e[k][31:0]);
                end
            end
        end
    endtask

    task automatic test_alias;
        logic [33:0] e_old [2];
        logic [33:0] e_new;
        drive_update(32'h0000_0050, 32'h0000_0300, 1'b1);
        // 4 entries: 0x50 evicts 0x40 (index 0); 16 entries: index 4, no conflict
        e_old[0] = pk(1'b0, 1'b0, 32'h0000_0044);
        e_old[1] = pk(1'b1, 1'b1, 32'h0000_0180);
        e_new    = pk(1'b1, 1'b1, 32'h0000_0300);
        curr_pc = 32'h0000_0040;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== e_old[d]) begin
                errors++;
                $display("FAIL alias_old dut%0d: got hit=%0b taken=%0b pc=%h, want hit=%0b taken=%0b pc=%h",
                         d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d], e_old[d][33], e_old[d][32], e_old[d][31:0]);
            end
        end
        curr_pc = 32'h0000_0050;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== e_new) begin
                errors++;
                $display("FAIL alias_new dut%0d: got hit=%0b taken=%0b pc=%h, want hit=%0b taken=%0b pc=%h",
                         d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d], e_new[33], e_new[32], e_new[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [33:0] e_before;
        logic [33:0] e_after;
        e_before = pk(1'b1, 1'b1, 32'h0000_0300);
        e_after  = pk(1'b1, 1'b0, 32'h0000_0054);
        curr_pc       = 32'h0000_0050;
        update_en     = 1'b1;
        update_pc     = 32'h0000_0050;
        update_target = 32'h0000_0333;
        update_taken  = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== e_before) begin
                errors++;
                $display("FAIL same_cycle_old dut%0d: got hit=%0b taken=%0b pc=%h, want hit=%0b taken=%0b pc=%h",
                         d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d], e_before[33], e_before[32], e_before[31:0]);
            end
        end
        next_cycle();
        update_en = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== e_after) begin
                errors++;
                $display("FAIL same_cycle_after dut%0d: got hit=%0b taken=%0b pc=%h, want hit=%0b taken=%0b pc=%h",
                         d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d], e_after[33], e_after[32], e_after[31:0]);
            end
        end
    endtask

    task automatic test_invalidate;
        word_t       u_pc  [3];
        word_t       u_tgt [3];
        logic        u_tk  [3];
        logic        u_inv [3];
        word_t       c_pc  [3];
        logic [33:0] e     [3];
        string       nm    [3];
        u_pc[0] = 32'hC0; u_tgt[0] = 32'h400; u_tk[0] = 1'b1; u_inv[0] = 1'b1; c_pc[0] = 32'h50; e[0] = pk(1'b0, 1'b0, 32'h54); nm[0] = "inv_clears";
        u_pc[1] = 32'h50; u_tgt[1] = 32'h500; u_tk[1] = 1'b0; u_inv[1] = 1'b0; c_pc[1] = 32'h50; e[1] = pk(1'b0, 1'b0, 32'h54); nm[1] = "inv_nt_no_alloc";
        u_pc[2] = 32'h50; u_tgt[2] = 32'h500; u_tk[2] = 1'b1; u_inv[2] = 1'b0; c_pc[2] = 32'h50; e[2] = pk(1'b1, 1'b1, 32'h500); nm[2] = "inv_realloc";
        for (int k = 0; k < 3; k++) begin
            invalidate = u_inv[k];
            drive_update(u_pc[k], u_tgt[k], u_tk[k]);
            invalidate = 1'b0;
            if (k == 0) begin
                // The update presented with the flush must not have landed.
                curr_pc = 32'h0000_00C0;
                #1;
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== pk(1'b0, 1'b0, 32'h0000_00C4)) begin
                        errors++;
                        $display("FAIL inv_drops_update dut%0d: got hit=%0b taken=%0b pc=%h, want hit=0 taken=0 pc=000000c4",
                                 d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]);
                    end
                end
            end
            curr_pc = c_pc[k];
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== e[k]) begin
                    errors++;
                    $display("FAIL %s dut%0d: got hit=%0b taken=%0b pc=%h, want hit=%0b taken=%0b pc=%h",
                             nm[k], d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d], e[k][33], e[k][32], e[k][31:0]);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 4; i++) begin
            drive_update(32'h0000_0060 + 32'(4 * i), 32'h0000_0600, 1'b1);
        end
        curr_pc = 32'h0000_006C;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== pk(1'b1, 1'b1, 32'h0000_0600)) begin
                errors++;
                $display("FAIL fill dut%0d: got hit=%0b taken=%0b pc=%h, want hit=1 taken=1 pc=00000600",
                         d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]);
            end
        end
        // Mid low phase, well away from any rising edge.
        nRST    = 1'b0;
        curr_pc = 32'h0000_0068;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== pk(1'b0, 1'b0, 32'h0000_006C)) begin
                errors++;
                $display("FAIL async_reset dut%0d: got hit=%0b taken=%0b pc=%h, want hit=0 taken=0 pc=0000006c",
                         d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]);
            end
        end
        @(negedge CLK);
        nRST    = 1'b1;
        next_cycle();
        curr_pc = 32'h0000_0050;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]} !== pk(1'b0, 1'b0, 32'h0000_0054)) begin
                errors++;
                $display("FAIL post_reset dut%0d: got hit=%0b taken=%0b pc=%h, want hit=0 taken=0 pc=00000054",
                         d, bp_hit_w[d], bp_taken_w[d], bp_pc_w[d]);
            end
        end
    endtask

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    // Test sequence.
    initial begin
        nRST          = 1'b0;
        curr_pc       = 32'h0000_0000;
        update_en     = 1'b0;
        update_pc     = 32'h0000_0000;
        update_target = 32'h0000_0000;
        update_taken  = 1'b0;
        invalidate    = 1'b0;
        test_reset();
        test_allocate();
        test_train();
        test_no_alloc_not_taken();
        test_alias();
        test_back_to_back();
        test_invalidate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
